torture_memsig: RTL and testbench
=================================

TORTURE_MEMSIG -- requirements
Module: torture_memsig

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, word-address bits; DEPTH = 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter FIXED_WAIT, default 0, minimum extra wait cycles per access.
REQ-003 SHALL have parameter RAND_WAIT_BITS, default 2, width of random extra wait; 0 disables randomness.
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have ports mem_valid in 1, mem_instr in 1, mem_addr in 32, mem_wdata in 32, mem_wstrb in 4: core native memory request.
REQ-008 SHALL have ports mem_ready out 1, mem_rdata out 32: response.
REQ-009 SHALL have port trap  input  1  core halted; starts signature check.
REQ-010 SHALL have ports ld_valid in 1, ld_sel in 1 (0=main, 1=ref), ld_addr in ADDR_WIDTH, ld_wdata in 32: preload.
REQ-011 SHALL have ports err_valid out 1, err_addr out ADDR_WIDTH, err_mem out 32, err_ref out 32: per-mismatch report.
REQ-012 SHALL have ports err_count out ADDR_WIDTH+1, oob out 1, done out 1, pass out 1: summary.

Function
REQ-013 SHALL contain main and ref arrays, DEPTH x 32 each; word index = mem_addr[ADDR_WIDTH+1:2].
REQ-014 SHALL run 16-bit Galois LFSR (taps 16,14,13,11), advancing every cycle out of reset.
REQ-015 SHALL implement states IDLE, WAIT, RESP, CHECK, DONE.
REQ-016 IDLE: ld_valid writes ld_wdata to selected array at ld_addr; loads accepted only in IDLE.
REQ-017 IDLE: mem_valid && !mem_ready && !trap && !ld_valid -> WAIT, latch request, load wait counter = FIXED_WAIT + lfsr[RAND_WAIT_BITS-1:0].
REQ-018 ld_valid and new mem_valid same cycle: load wins; request taken next eligible cycle.
REQ-019 WAIT: counter zero -> RESP, else decrement; counter loaded 0 gives mem_ready 1 cycle after acceptance.
REQ-020 RESP: mem_ready high exactly one cycle; wstrb nonzero -> write enabled byte lanes, mem_rdata 0; wstrb zero -> mem_rdata = main word; then IDLE.
REQ-021 mem_rdata SHALL be 32'h0 whenever mem_ready is low.
REQ-022 mem_addr[31:ADDR_WIDTH+2] nonzero: write suppressed, read returns 32'h0, oob set sticky; mem_ready still given.
REQ-023 trap in IDLE -> CHECK at index 0; trap during WAIT/RESP: pending access completes, then CHECK.
REQ-024 CHECK: one word per cycle; main != ref -> err_valid 1-cycle pulse with err_addr, err_mem, err_ref, err_count increments.
REQ-025 CHECK after index DEPTH-1 -> DONE; err_count cannot overflow (max DEPTH).
REQ-026 DONE: done=1, pass = (err_count==0 && !oob); held until reset; mem_valid ignored, mem_ready 0.
REQ-027 mem_valid, ld_valid ignored in CHECK and DONE.

Reset
REQ-028 reset SHALL asynchronously force IDLE, mem_ready 0, mem_rdata 0, err_valid 0, err_count 0, oob 0, done 0, pass 0, lfsr LFSR_SEED.
REQ-029 array contents SHALL NOT be reset; reset mid-WAIT drops request, mid-CHECK aborts scan; restart re-checks from index 0.

Verification
REQ-030 FIXED_WAIT=0, RAND_WAIT_BITS=0: read addr 0x10 holding 32'h12345678 -> mem_ready one cycle after acceptance, mem_rdata 32'h12345678.
REQ-031 write 0x20 wdata 32'hAABBCCDD wstrb 4'b0101 over 32'h0 -> word 32'h00BB00DD on readback.
REQ-032 FIXED_WAIT=2, RAND_WAIT_BITS=2: 1000 reads -> latency always 3..6 cycles, each value observed, data correct.
REQ-033 ADDR_WIDTH=4, main==ref, trap -> 16 CHECK cycles, no err_valid, done=1, pass=1, err_count 0.
REQ-034 ADDR_WIDTH=4, words 3 and 15 differ -> err_valid at err_addr 3 then 15, err_count 2, pass 0.
REQ-035 read 0x0004_0000 with ADDR_WIDTH=12 -> mem_rdata 0, oob 1, pass 0 after check even with matching arrays; reset mid-CHECK -> all outputs 0.

Source files
------------

// File: rtl/torture_memsig.sv
// torture_memsig: core memory model with LFSR wait states and post-trap signature compare
module torture_memsig #(
  parameter int ADDR_WIDTH = 12,
  parameter int FIXED_WAIT = 0,
  parameter int RAND_WAIT_BITS = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_valid,
  input  logic mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0] mem_wstrb,
  output logic mem_ready,
  output logic [31:0] mem_rdata,
  input  logic trap,
  input  logic ld_valid,
  input  logic ld_sel,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [31:0] err_mem,
  output logic [31:0] err_ref,
  output logic [ADDR_WIDTH:0] err_count,
  output logic oob,
  output logic done,
  output logic pass
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [2:0] IDLE = 3'd0, WAIT = 3'd1, RESP = 3'd2, CHECK = 3'd3, DONE = 3'd4;
  localparam logic [15:0] RMASK = 16'((32'd1 << RAND_WAIT_BITS) - 32'd1);
  logic [2:0] state, state_nx;
  logic [15:0] lfsr;
  logic [31:0] cnt, req_addr, req_wdata;
  logic [3:0] req_wstrb;
  logic trap_pend, req_oob, fire, accept, mismatch, unused_ok;
  logic [ADDR_WIDTH-1:0] idx, req_idx;
  logic [31:0] main_mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  assign req_idx = req_addr[ADDR_WIDTH+1:2];
  assign req_oob = |(req_addr >> (ADDR_WIDTH + 2));
  assign fire = state == WAIT && cnt == 0;
  assign accept = state == IDLE && mem_valid && !mem_ready && !trap && !ld_valid;
  assign mismatch = main_mem[idx] != ref_mem[idx];
  assign done = state == DONE;
  assign pass = done && err_count == '0 && !oob;
  assign unused_ok = ^{mem_instr, req_addr[1:0]};
  always_comb
    state_nx = state == IDLE  ? (trap ? CHECK : accept ? WAIT : IDLE) :
               state == WAIT  ? (cnt == 0 ? RESP : WAIT) :
               state == RESP  ? (trap || trap_pend ? CHECK : IDLE) :
               state == CHECK ? (idx == ADDR_WIDTH'(DEPTH - 1) ? DONE : CHECK) : DONE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      lfsr <= LFSR_SEED;
      cnt <= '0;
      req_addr <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      trap_pend <= 1'b0;
      idx <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      err_valid <= 1'b0;
      err_addr <= '0;
      err_mem <= '0;
      err_ref <= '0;
      err_count <= '0;
      oob <= 1'b0;
    end else begin
      state <= state_nx;
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0);
      mem_ready <= fire;
      mem_rdata <= fire && req_wstrb == 4'h0 && !req_oob ? main_mem[req_idx] : 32'h0;
      err_valid <= state == CHECK && mismatch;
      if (state == CHECK && mismatch) begin
        err_addr <= idx;
        err_mem <= main_mem[idx];
        err_ref <= ref_mem[idx];
        err_count <= err_count + 1'b1;
      end
      if (fire && req_oob) oob <= 1'b1;
      if (state inside {WAIT, RESP} && trap) trap_pend <= 1'b1;
      if (accept) begin
        req_addr <= mem_addr;
        req_wdata <= mem_wdata;
        req_wstrb <= mem_wstrb;
        cnt <= 32'(FIXED_WAIT) + {16'h0, lfsr & RMASK};
      end else if (state == WAIT && cnt != 0) cnt <= cnt - 1;
      idx <= state == CHECK ? idx + 1'b1 : '0;
    end
  always_ff @(posedge clk) begin
    if (state == IDLE && ld_valid && !ld_sel) main_mem[ld_addr] <= ld_wdata;
    if (state == IDLE && ld_valid && ld_sel) ref_mem[ld_addr] <= ld_wdata;
    if (fire && !req_oob)
      for (int b = 0; b < 4; b++)
        if (req_wstrb[b]) main_mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_torture_memsig.sv
// tb_torture_memsig: two instances (small zero-wait, full-size random-wait) against a model
module tb_torture_memsig;
  logic clk = 1'b0, rst = 1'b1, instr = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] mem_valid, trap, ld_valid, ld_sel, mem_ready, err_valid, oob, done, pass;
  logic [1:0][31:0] mem_addr, mem_wdata, ld_wdata, mem_rdata, err_mem, err_ref;
  logic [1:0][3:0] mem_wstrb;
  logic [3:0] ld_addr_a, err_addr_a;
  logic [11:0] ld_addr_b, err_addr_b;
  logic [4:0] err_count_a;
  logic [12:0] err_count_b;
  int tests = 0, fails = 0;
  logic [31:0] ma [16];
  logic [31:0] ra [16];
  logic [31:0] mb [4096];
  int eq_addr[$];
  logic [31:0] eq_mem[$];
  logic [31:0] eq_ref[$];

  torture_memsig #(.ADDR_WIDTH(4), .FIXED_WAIT(0), .RAND_WAIT_BITS(0)) dut_a (
    .clk(clk), .reset(rst), .mem_valid(mem_valid[0]), .mem_instr(instr), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]), .mem_ready(mem_ready[0]), .mem_rdata(mem_rdata[0]),
    .trap(trap[0]), .ld_valid(ld_valid[0]), .ld_sel(ld_sel[0]), .ld_addr(ld_addr_a), .ld_wdata(ld_wdata[0]),
    .err_valid(err_valid[0]), .err_addr(err_addr_a), .err_mem(err_mem[0]), .err_ref(err_ref[0]),
    .err_count(err_count_a), .oob(oob[0]), .done(done[0]), .pass(pass[0]));

  torture_memsig #(.ADDR_WIDTH(12), .FIXED_WAIT(2), .RAND_WAIT_BITS(2)) dut_b (
    .clk(clk), .reset(rst), .mem_valid(mem_valid[1]), .mem_instr(instr), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]), .mem_ready(mem_ready[1]), .mem_rdata(mem_rdata[1]),
    .trap(trap[1]), .ld_valid(ld_valid[1]), .ld_sel(ld_sel[1]), .ld_addr(ld_addr_b), .ld_wdata(ld_wdata[1]),
    .err_valid(err_valid[1]), .err_addr(err_addr_b), .err_mem(err_mem[1]), .err_ref(err_ref[1]),
    .err_count(err_count_b), .oob(oob[1]), .done(done[1]), .pass(pass[1]));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic [31:0] rdata;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] w, logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (w & m);
  endfunction

  task automatic load(int d, logic sel, int addr, logic [31:0] data);
    ld_valid[d] = 1'b1;
    ld_sel[d] = sel;
    if (d == 0) ld_addr_a = 4'(addr);
    else ld_addr_b = 12'(addr);
    ld_wdata[d] = data;
    tick();
    ld_valid[d] = 1'b0;
  endtask

  // lat = cycles from the accepting edge to the first cycle mem_ready is seen high
  task automatic access(int d, logic [31:0] addr, logic [31:0] wdata, logic [3:0] wstrb,
                        output logic [31:0] rdata, output int lat);
    mem_valid[d] = 1'b1;
    mem_addr[d] = addr;
    mem_wdata[d] = wdata;
    mem_wstrb[d] = wstrb;
    lat = -1;
    rdata = 'x;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_ready[d]) begin
        lat = i;
        rdata = mem_rdata[d];
        break;
      end
    end
    mem_valid[d] = 1'b0;
    if (lat < 0) begin
      tests++;
      fails++;
      $display("FAIL access timeout dut%0d addr %h", d, addr);
    end
    tick();
    chk("ready one cycle", {31'h0, mem_ready[d]}, 32'h0);
    chk("rdata idle zero", mem_rdata[d], 32'h0);
  endtask

  task automatic scan(int d, output int cyc);
    eq_addr.delete();
    eq_mem.delete();
    eq_ref.delete();
    trap[d] = 1'b1;
    cyc = -1;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (err_valid[d]) begin
        eq_addr.push_back(d == 0 ? int'(err_addr_a) : int'(err_addr_b));
        eq_mem.push_back(err_mem[d]);
        eq_ref.push_back(err_ref[d]);
      end
      if (done[d]) begin
        cyc = i;
        break;
      end
    end
    if (cyc < 0) begin
      tests++;
      fails++;
      $display("FAIL scan timeout dut%0d", d);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    logic [31:0] rd;
    int lat, cyc, n;
    int xa[$];
    logic [31:0] xm[$];
    logic [31:0] xr[$];
    bit seen[7];
    vecs[0] = '{32'h10, 32'h12345678, 4'hF, 32'h0};
    vecs[1] = '{32'h10, 32'h0, 4'h0, 32'h12345678};
    vecs[2] = '{32'h20, 32'hAABBCCDD, 4'h5, 32'h0};
    vecs[3] = '{32'h20, 32'h0, 4'h0, 32'h00BB00DD};
    vecs[4] = '{32'h20, 32'h11223344, 4'hA, 32'h0};
    vecs[5] = '{32'h20, 32'h0, 4'h0, 32'h11BB33DD};
    vecs[6] = '{32'h3C, 32'hDEADBEEF, 4'h8, 32'h0};
    vecs[7] = '{32'h3C, 32'h0, 4'h0, 32'hDE000000};
    mem_valid = '0; trap = '0; ld_valid = '0; ld_sel = '0;
    mem_addr = '0; mem_wdata = '0; ld_wdata = '0; mem_wstrb = '0;
    ld_addr_a = '0; ld_addr_b = '0;
    rst = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("reset mem_ready", {31'h0, mem_ready[d]}, 32'h0);
      chk("reset rdata", mem_rdata[d], 32'h0);
      chk("reset done", {31'h0, done[d]}, 32'h0);
      chk("reset pass", {31'h0, pass[d]}, 32'h0);
      chk("reset oob", {31'h0, oob[d]}, 32'h0);
      chk("reset err_valid", {31'h0, err_valid[d]}, 32'h0);
    end
    chk("reset err_count_a", {27'h0, err_count_a}, 32'h0);
    chk("reset err_count_b", {19'h0, err_count_b}, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      ma[i] = 32'h0;
      ra[i] = 32'h0;
      load(0, 1'b0, i, 32'h0);
      load(0, 1'b1, i, 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      access(0, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, lat);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].rdata);
      chk($sformatf("vec%0d latency", i), lat, 1);
      if (vecs[i].wstrb != 4'h0)
        ma[vecs[i].addr[5:2]] = merge(ma[vecs[i].addr[5:2]], vecs[i].wdata, vecs[i].wstrb);
    end

    // load and request in the same cycle: the load lands first, request accepted one edge later
    ld_valid[0] = 1'b1; ld_sel[0] = 1'b0; ld_addr_a = 4'd5; ld_wdata[0] = 32'hCAFEF00D;
    mem_valid[0] = 1'b1; mem_addr[0] = 32'h14; mem_wstrb[0] = 4'h0;
    tick();
    ld_valid[0] = 1'b0;
    chk("collide no ready", {31'h0, mem_ready[0]}, 32'h0);
    ma[5] = 32'hCAFEF00D;
    access(0, 32'h14, 32'h0, 4'h0, rd, lat);
    chk("collide rdata", rd, 32'hCAFEF00D);
    chk("collide latency", lat, 1);

    for (int k = 0; k < 200; k++) begin
      logic [3:0] ix, ws;
      logic [31:0] wd;
      ix = 4'($urandom_range(0, 15));
      ws = $urandom_range(0, 1) == 1 ? 4'($urandom_range(1, 15)) : 4'h0;
      wd = $urandom;
      access(0, {26'h0, ix, 2'($urandom)}, wd, ws, rd, lat);
      chk("rand_a rdata", rd, ws == 4'h0 ? ma[ix] : 32'h0);
      chk("rand_a latency", lat, 1);
      if (ws != 4'h0) ma[ix] = merge(ma[ix], wd, ws);
    end

    for (int i = 0; i < 16; i++) begin
      ra[i] = ma[i];
      load(0, 1'b1, i, ra[i]);
    end
    scan(0, cyc);
    chk("match cycles", cyc, 16);
    chk("match errs", eq_addr.size(), 0);
    chk("match done", {31'h0, done[0]}, 32'h1);
    chk("match pass", {31'h0, pass[0]}, 32'h1);
    chk("match count", {27'h0, err_count_a}, 32'h0);
    trap[0] = 1'b0;
    do_reset();
    chk("post reset done", {31'h0, done[0]}, 32'h0);

    ra[3] = ma[3] ^ 32'h1;
    ra[15] = ~ma[15];
    load(0, 1'b1, 3, ra[3]);
    load(0, 1'b1, 15, ra[15]);
    xa.delete(); xm.delete(); xr.delete();
    for (int i = 0; i < 16; i++)
      if (ma[i] != ra[i]) begin
        xa.push_back(i);
        xm.push_back(ma[i]);
        xr.push_back(ra[i]);
      end
    scan(0, cyc);
    chk("diff cycles", cyc, 16);
    n = xa.size();
    chk("diff err pulses", eq_addr.size(), n);
    for (int i = 0; i < n && i < eq_addr.size(); i++) begin
      chk($sformatf("diff%0d addr", i), eq_addr[i], xa[i]);
      chk($sformatf("diff%0d mem", i), eq_mem[i], xm[i]);
      chk($sformatf("diff%0d ref", i), eq_ref[i], xr[i]);
    end
    chk("diff count", {27'h0, err_count_a}, n);
    chk("diff pass", {31'h0, pass[0]}, 32'h0);
    chk("diff done", {31'h0, done[0]}, 32'h1);
    trap[0] = 1'b0;
    do_reset();

    for (int i = 0; i < 4096; i++) begin
      mb[i] = $urandom;
      load(1, 1'b0, i, mb[i]);
      load(1, 1'b1, i, mb[i]);
    end
    for (int k = 0; k < 1000; k++) begin
      logic [11:0] ix;
      ix = 12'($urandom_range(0, 4095));
      access(1, {18'h0, ix, 2'($urandom)}, 32'h0, 4'h0, rd, lat);
      chk("rand_b rdata", rd, mb[ix]);
      chk("rand_b latency range", {31'h0, lat >= 3 && lat <= 6}, 32'h1);
      if (lat >= 3 && lat <= 6) seen[lat] = 1'b1;
    end
    for (int l = 3; l <= 6; l++) chk($sformatf("latency %0d seen", l), {31'h0, seen[l]}, 32'h1);

    // out-of-range read with trap raised while it waits
    mem_valid[1] = 1'b1; mem_addr[1] = 32'h0004_0000; mem_wstrb[1] = 4'h0;
    tick();
    trap[1] = 1'b1;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (mem_ready[1]) begin
        lat = i;
        break;
      end
      tick();
    end
    chk("oob ready seen", {31'h0, lat >= 0}, 32'h1);
    chk("oob rdata", mem_rdata[1], 32'h0);
    mem_valid[1] = 1'b0;
    tick();
    chk("oob sticky", {31'h0, oob[1]}, 32'h1);
    scan(1, cyc);
    chk("oob errs", eq_addr.size(), 0);
    chk("oob done", {31'h0, done[1]}, 32'h1);
    chk("oob pass", {31'h0, pass[1]}, 32'h0);
    chk("oob count", {19'h0, err_count_b}, 32'h0);
    trap[1] = 1'b0;
    do_reset();

    trap[1] = 1'b1;
    repeat (100) tick();
    trap[1] = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst done", {31'h0, done[1]}, 32'h0);
    chk("midrst pass", {31'h0, pass[1]}, 32'h0);
    chk("midrst oob", {31'h0, oob[1]}, 32'h0);
    chk("midrst err_valid", {31'h0, err_valid[1]}, 32'h0);
    chk("midrst count", {19'h0, err_count_b}, 32'h0);
    chk("midrst ready", {31'h0, mem_ready[1]}, 32'h0);
    chk("midrst rdata", mem_rdata[1], 32'h0);
    chk("midrst err_addr", {20'h0, err_addr_b}, 32'h0);
    chk("midrst err_mem", err_mem[1], 32'h0);
    chk("midrst err_ref", err_ref[1], 32'h0);
    tick();
    rst = 1'b0;
    tick();
    scan(1, cyc);
    chk("rescan cycles", cyc, 4096);
    chk("rescan errs", eq_addr.size(), 0);
    chk("rescan pass", {31'h0, pass[1]}, 32'h1);
    trap[1] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
